// File: rtl/bus_turnaround_ctrl_if.sv
// bus_turnaround_ctrl_if: line samples, transmitter handshake and status between controller and transmitter
interface bus_turnaround_ctrl_if;
  logic d_plus_in;
  logic d_minus_in;
  logic tx_req;
  logic expect_resp;
  logic tx_done;
  logic tx_grant;
  logic rx_enable;
  logic timeout_err;
  logic [2:0] state_dbg;
  modport slave (
    input d_plus_in, d_minus_in, tx_req, expect_resp, tx_done,
    output tx_grant, rx_enable, timeout_err, state_dbg
  );
  modport master (
    output d_plus_in, d_minus_in, tx_req, expect_resp, tx_done,
    input tx_grant, rx_enable, timeout_err, state_dbg
  );
endinterface

// File: rtl/bus_turnaround_ctrl.sv
// bus_turnaround_ctrl: half-duplex D+/D- ownership arbiter with idle turnaround gaps and response timeout
module bus_turnaround_ctrl #(
  parameter int TURN_CYCLES = 4,
  parameter int RESP_TIMEOUT = 16,
  parameter int EOP_MIN = 2
) (
  input logic clk,
  input logic n_rst,
  bus_turnaround_ctrl_if.slave bus
);
  localparam int MAXC = TURN_CYCLES > RESP_TIMEOUT ? TURN_CYCLES : RESP_TIMEOUT;
  localparam int CW = $clog2(MAXC + 1);
  localparam int EW = $clog2(EOP_MIN + 1);
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RX_ACTIVE = 3'd1,
    TURN_TX = 3'd2,
    TX_ACTIVE = 3'd3,
    TURN_RX = 3'd4,
    RESP_WAIT = 3'd5
  } state_t;
  state_t state, state_n;
  logic [1:0] sp_q, sm_q;
  logic [CW-1:0] cnt, cnt_n;
  logic [EW-1:0] se0_cnt, se0_cnt_n;
  logic exp_q, exp_n, err_n, timeout_q;
  logic line_j, line_se0;
  assign line_j = sp_q[1] & ~sm_q[1];
  assign line_se0 = ~sp_q[1] & ~sm_q[1];
  assign bus.tx_grant = state == TX_ACTIVE;
  assign bus.rx_enable = state == IDLE || state == RX_ACTIVE || state == RESP_WAIT;
  assign bus.timeout_err = timeout_q;
  assign bus.state_dbg = state;
  // Synchronizers (reset to J so a reset never looks like activity), state, counters and error pulse
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sp_q <= 2'b11;
      sm_q <= 2'b00;
      state <= IDLE;
      cnt <= '0;
      se0_cnt <= '0;
      exp_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sp_q <= {sp_q[0], bus.d_plus_in};
      sm_q <= {sm_q[0], bus.d_minus_in};
      state <= state_n;
      cnt <= cnt_n;
      se0_cnt <= se0_cnt_n;
      exp_q <= exp_n;
      timeout_q <= err_n;
    end
  end
  // Next-state logic; line activity beats requests and timeouts, the SE0 run only lives in RX_ACTIVE
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    se0_cnt_n = '0;
    exp_n = exp_q;
    err_n = 1'b0;
    case (state)
      IDLE: begin
        if (!line_j) state_n = RX_ACTIVE;
        else if (bus.tx_req) begin
          state_n = TURN_TX;
          cnt_n = '0;
          exp_n = bus.expect_resp;
        end
      end
      RX_ACTIVE: begin
        se0_cnt_n = !line_se0 ? '0 : se0_cnt == EW'(EOP_MIN) ? se0_cnt : se0_cnt + 1'b1;
        if (line_j && se0_cnt >= EW'(EOP_MIN)) state_n = IDLE;
      end
      TURN_TX: begin
        if (!line_j) state_n = RX_ACTIVE;
        else if (!bus.tx_req) state_n = IDLE;
        else begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == CW'(TURN_CYCLES)) state_n = TX_ACTIVE;
        end
      end
      TX_ACTIVE: begin
        if (bus.tx_done) begin
          state_n = TURN_RX;
          cnt_n = '0;
        end
      end
      TURN_RX: begin
        cnt_n = cnt + 1'b1;
        if (cnt_n == CW'(TURN_CYCLES)) begin
          state_n = exp_q ? RESP_WAIT : IDLE;
          cnt_n = '0;
        end
      end
      RESP_WAIT: begin
        if (!line_j) state_n = RX_ACTIVE;
        else begin
          cnt_n = cnt + 1'b1;
          if (cnt_n == CW'(RESP_TIMEOUT)) begin
            state_n = IDLE;
            err_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bus_turnaround_ctrl.sv
// tb_bus_turnaround_ctrl: directed scenarios plus randomized traffic checked against a countdown-based behavioural model
module tb_bus_turnaround_ctrl;
  localparam int TC = 4, RT = 16, EM = 2;
  localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00, LSE1 = 2'b11;
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;
  bus_turnaround_ctrl_if bus();
  bus_turnaround_ctrl #(.TURN_CYCLES(TC), .RESP_TIMEOUT(RT), .EOP_MIN(EM)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );
  int tests = 0, fails = 0;
  typedef enum int {M_IDLE = 0, M_RX = 1, M_PRE = 2, M_TX = 3, M_POST = 4, M_WAIT = 5} mode_t;
  mode_t md;
  int left, se0n;
  bit ex, err_m, saw_rx, g_seen;
  logic [1:0] s1, s2;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic void mreset();
    md = M_IDLE; left = 0; se0n = 0; ex = 0; err_m = 0; s1 = LJ; s2 = LJ;
  endfunction
  function automatic void mstep();
    bit j, se0;
    j = s2 == LJ;
    se0 = s2 == LSE0;
    err_m = 0;
    case (md)
      M_IDLE: if (!j) begin md = M_RX; se0n = 0; end
              else if (bus.tx_req) begin md = M_PRE; left = TC; ex = bus.expect_resp; end
      M_RX: if (se0) se0n = (se0n + 1 > EM) ? EM : se0n + 1;
            else if (j && se0n >= EM) md = M_IDLE;
            else se0n = 0;
      M_PRE: if (!j) begin md = M_RX; se0n = 0; end
             else if (!bus.tx_req) md = M_IDLE;
             else begin left--; if (left == 0) md = M_TX; end
      M_TX: if (bus.tx_done) begin md = M_POST; left = TC; end
      M_POST: begin
        left--;
        if (left == 0) begin
          md = ex ? M_WAIT : M_IDLE;
          left = RT;
        end
      end
      M_WAIT: if (!j) begin md = M_RX; se0n = 0; end
              else begin left--; if (left == 0) begin md = M_IDLE; err_m = 1; end end
      default: md = M_IDLE;
    endcase
    s2 = s1;
    s1 = {bus.d_plus_in, bus.d_minus_in};
  endfunction
  task automatic compare_all();
    check("tx_grant", bus.tx_grant, md == M_TX);
    check("rx_enable", bus.rx_enable, md == M_IDLE || md == M_RX || md == M_WAIT);
    check("timeout_err", bus.timeout_err, err_m);
    check("state_dbg", bus.state_dbg, int'(md));
  endtask
  task automatic cyc(input logic [1:0] ln, input logic req, input logic er, input logic done);
    {bus.d_plus_in, bus.d_minus_in} = ln;
    bus.tx_req = req;
    bus.expect_resp = er;
    bus.tx_done = done;
    @(posedge clk);
    mstep();
    @(negedge clk);
    compare_all();
    if (bus.state_dbg == 3'd1) saw_rx = 1;
    if (bus.tx_grant) g_seen = 1;
  endtask
  task automatic async_reset();
    #2 n_rst = 1'b0;
    #1;
    mreset();
    check("rst_async_grant", bus.tx_grant, 0);
    check("rst_async_rxen", bus.rx_enable, 1);
    check("rst_async_state", bus.state_dbg, 0);
    check("rst_async_err", bus.timeout_err, 0);
    @(negedge clk);
    n_rst = 1'b1;
  endtask
  initial begin
    int n;
    logic [1:0] ln;
    logic req;
    int bias;
    mreset();
    {bus.d_plus_in, bus.d_minus_in} = LJ;
    bus.tx_req = 0; bus.expect_resp = 0; bus.tx_done = 0;
    @(negedge clk);
    @(negedge clk);
    check("reset_grant", bus.tx_grant, 0);
    check("reset_rxen", bus.rx_enable, 1);
    check("reset_err", bus.timeout_err, 0);
    check("reset_state", bus.state_dbg, 0);
    n_rst = 1'b1;
    // basic transmission without response
    repeat (3) cyc(LJ, 0, 0, 0);
    n = 0;
    do begin cyc(LJ, 1, 0, 0); n++; end while (!bus.tx_grant && n < 20);
    check("grant_latency", n, TC + 1);
    cyc(LK, 0, 0, 0);
    cyc(LK, 0, 0, 0);
    check("tx_ignores_line", bus.state_dbg, 3);
    cyc(LJ, 0, 0, 1);
    check("grant_fall", bus.tx_grant, 0);
    repeat (3) cyc(LJ, 0, 0, 0);
    check("turn_rx_hold", bus.state_dbg, 4);
    cyc(LJ, 0, 0, 0);
    check("idle_after_turn", bus.state_dbg, 0);
    // response expected, line stays J -> timeout
    n = 0;
    do begin cyc(LJ, 1, 1, 0); n++; end while (!bus.tx_grant && n < 20);
    cyc(LJ, 0, 0, 1);
    repeat (4) cyc(LJ, 0, 0, 0);
    check("resp_wait_entry", bus.state_dbg, 5);
    n = 0;
    do begin cyc(LJ, 0, 0, 0); n++; end while (!bus.timeout_err && n < 40);
    check("timeout_cycles", n, RT);
    check("timeout_to_idle", bus.state_dbg, 0);
    cyc(LJ, 0, 0, 0);
    check("timeout_single", bus.timeout_err, 0);
    // K and tx_req seen together: activity wins
    g_seen = 0;
    cyc(LK, 0, 0, 0);
    cyc(LK, 0, 0, 0);
    cyc(LK, 1, 0, 0);
    check("k_beats_req", bus.state_dbg, 1);
    repeat (4) cyc(LK, 1, 0, 0);
    check("k_no_grant", g_seen, 0);
    // EOP qualification
    cyc(LSE0, 0, 0, 0);
    repeat (4) cyc(LJ, 0, 0, 0);
    check("short_se0_stays_rx", bus.state_dbg, 1);
    cyc(LSE0, 0, 0, 0);
    cyc(LSE0, 0, 0, 0);
    repeat (4) cyc(LJ, 0, 0, 0);
    check("eop_to_idle", bus.state_dbg, 0);
    // activity during TURN_TX aborts; retry with tx_req held
    g_seen = 0; saw_rx = 0;
    cyc(LJ, 1, 0, 0);
    check("turn_tx_entry", bus.state_dbg, 2);
    cyc(LK, 1, 0, 0);
    cyc(LSE0, 1, 0, 0);
    cyc(LSE0, 1, 0, 0);
    n = 0;
    do begin cyc(LJ, 1, 0, 0); n++; end while (bus.state_dbg != 3'd0 && n < 12);
    check("abort_saw_rx", saw_rx, 1);
    check("abort_no_grant", g_seen, 0);
    check("abort_back_idle", bus.state_dbg, 0);
    n = 0;
    do begin cyc(LJ, 1, 0, 0); n++; end while (!bus.tx_grant && n < 20);
    check("retry_latency", n, TC + 1);
    // async reset in TX_ACTIVE
    cyc(LJ, 0, 0, 0);
    check("pre_reset_grant", bus.tx_grant, 1);
    async_reset();
    repeat (2) cyc(LJ, 0, 0, 0);
    // randomized traffic
    req = 0;
    for (int s = 0; s < 15; s++) begin
      case ($urandom_range(2))
        0: bias = 50;
        1: bias = 85;
        default: bias = 97;
      endcase
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(99) < bias) ln = LJ;
        else case ($urandom_range(3))
          0, 1: ln = LSE0;
          2: ln = LK;
          default: ln = LSE1;
        endcase
        if ($urandom_range(9) == 0) req = ~req;
        if ($urandom_range(399) == 0) async_reset();
        else cyc(ln, req, 1'($urandom_range(1)), $urandom_range(99) < 8);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
